traffic_signal_rr: RTL
======================

// Module: traffic_signal_rr
// PURPOSE
//  Parametrised N-way intersection controller; next generation of the 2-way sensor-driven light FSM.
//  Serves N_CH approaches round-robin with min/max green timers, yellow and all-red clearance
//  intervals, demand-skip, and a flashing maintenance mode. Drives the lamp decoders of the board.
// PARAMETERS
//  N_CH        2   number of approaches (>=2)
//  MIN_GREEN   8   minimum green length, cycles (>=1)
//  MAX_GREEN   32  max green length while another approach waits (>=MIN_GREEN)
//  YELLOW_CYC  3   yellow length, cycles (>=1)
//  ALLRED_CYC  2   all-red clearance length, cycles (>=1)
//  FLASH_HALF  4   flash-mode half period, cycles (>=1)
// PORTS
//  clk        in   1           system clock, rising edge
//  reset      in   1           asynchronous, active-low reset
//  T          in   N_CH        traffic sensor per approach, 1 = vehicle waiting/present
//  flash      in   1           1 = maintenance flashing mode
//  sig        out  2*N_CH      lamp code, approach i on sig[2i+1:2i]: 00 red, 01 yellow, 10 green
//  active_ch  out  clog2(N_CH) approach currently owning green/yellow
//  phase      out  2           current FSM state code (debug)
// BEHAVIOUR
//  - Reset (reset=0, async): state GREEN, active_ch=0, phase_cnt=0, flash_on=0; sig = ch0 green,
//    all others red; phase=GREEN. All outputs registered; change only on clk edge after reset.
//  - States/codes: GREEN=00, YELLOW=01, ALLRED=10, FLASH=11. phase_cnt counts cycles in state,
//    0 on entry, saturates at MAX_GREEN-1.
//  - other_dem = |(T & ~onehot(active_ch)).
//  - GREEN -> YELLOW when phase_cnt>=MIN_GREEN-1 && other_dem && (!T[active_ch] || phase_cnt>=MAX_GREEN-1).
//    No other demand: green held indefinitely regardless of T[active_ch].
//  - YELLOW -> ALLRED after exactly YELLOW_CYC cycles; ALLRED -> GREEN after exactly ALLRED_CYC cycles.
//  - On ALLRED->GREEN, active_ch = first approach with T set, searching active_ch+1, +2, ... with
//    wrap (N_CH-1 -> 0); if none set at that edge, active_ch+1 mod N_CH. Choice sampled on that edge only.
//  - sig: active_ch shows 10 in GREEN, 01 in YELLOW; every other approach 00; ALLRED all 00.
//  - flash=1 in any state: next edge -> FLASH, phase_cnt=0, flash_on=1. In FLASH all approaches show 01
//    while flash_on else 00; flash_on toggles every FLASH_HALF cycles.
//  - flash=0 in FLASH: next edge -> ALLRED (full ALLRED_CYC), then GREEN with active_ch=0 unconditionally.
//  - flash has priority over every timer transition occurring on the same edge.
//  - T and flash are synchronous inputs (synchronisers live upstream).
// STRUCTURE
//  - Package traffic_pkg: lamp codes (LAMP_RED/YELLOW/GREEN), state codes, phase_cnt width function.
//  - Sub-module rr_next_sel (N_CH): combinational rotate-priority pick of next demanded approach
//    from T and active_ch; returns index + valid.
//  - Top: state reg, phase_cnt, flash_on, active_ch regs; next-state and lamp decode logic.
// TESTING (defaults unless noted; cycle 0 = first edge after reset release)
//  1. T=00, flash=0 for 100 cycles -> sig=4'b0010 throughout, active_ch=0, phase=GREEN.
//  2. T=11 -> ch0 green cycles 0-31, yellow 32-34, all-red 35-36, ch1 green from 37 (max-green cutoff).
//  3. T=10 -> ch0 green 0-7, yellow 8-10, all-red 11-12, ch1 green from 13; T=00 after -> ch1 held.
//  4. N_CH=4, ch0 green, T=4'b0100 -> after clearance active_ch=2 (ch1 skipped); T dropped to 0
//     during ALLRED -> active_ch=1.
//  5. flash=1 mid-YELLOW -> next edge all 01 for 4 cycles, all 00 for 4, repeat; flash=0 -> 2 cycles
//     all 00 then ch0 green.
//  6. reset=0 mid-ALLRED (between edges) -> sig=ch0 green, phase=GREEN immediately, no clk needed;
//     normal sequencing resumes after release.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp/state codes and sizing helpers for the round-robin intersection controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    StGreen  = 2'b00,
    StYellow = 2'b01,
    StAllRed = 2'b10,
    StFlash  = 2'b11
  } state_e;

  localparam logic [1:0] LampRed    = 2'b00;
  localparam logic [1:0] LampYellow = 2'b01;
  localparam logic [1:0] LampGreen  = 2'b10;

  // Bits needed to count n_states distinct values, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n_states);
    return (n_states > 1) ? $clog2(n_states) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Rotate-priority pick of the next demanded approach, starting just after the current owner.
module rr_next_sel
  import traffic_pkg::*;
#(
  parameter int unsigned N_CH = 2,
  localparam int unsigned ChW = cnt_width(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [ChW-1:0]  cur_i,
  output logic [ChW-1:0]  idx_o,
  output logic            valid_o
);

  int unsigned cand;

  // Offsets 1..N_CH: the current owner itself is the last candidate.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned off = 1; off <= N_CH; off++) begin
      cand = 32'(cur_i) + off;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!valid_o && |(req_i & (N_CH'(1) << cand))) begin
        idx_o   = ChW'(cand);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_signal_rr.sv
// N-way round-robin traffic controller: min/max green, yellow, all-red clearance, demand skip
// and flashing maintenance mode. All outputs come straight from registers.
module traffic_signal_rr
  import traffic_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned MAX_GREEN  = 32,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned FLASH_HALF = 4,
  localparam int unsigned ChW = cnt_width(N_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_CH-1:0]   t_i,
  input  logic              flash_i,
  output logic [2*N_CH-1:0] sig_o,
  output logic [ChW-1:0]    active_ch_o,
  output logic [1:0]        phase_o
);

  localparam int unsigned SigW   = 2 * N_CH;
  localparam int unsigned CntTop = max_u(max_u(MAX_GREEN, YELLOW_CYC),
                                         max_u(ALLRED_CYC, FLASH_HALF));
  localparam int unsigned CntW   = cnt_width(CntTop);

  localparam logic [CntW-1:0] CntSat    = CntW'(CntTop - 1);
  localparam logic [CntW-1:0] MinLast   = CntW'(MIN_GREEN - 1);
  localparam logic [CntW-1:0] MaxLast   = CntW'(MAX_GREEN - 1);
  localparam logic [CntW-1:0] YelLast   = CntW'(YELLOW_CYC - 1);
  localparam logic [CntW-1:0] RedLast   = CntW'(ALLRED_CYC - 1);
  localparam logic [CntW-1:0] FlashLast = CntW'(FLASH_HALF - 1);
  localparam logic [ChW-1:0]  LastCh    = ChW'(N_CH - 1);
  localparam logic [SigW-1:0] ResetSig  = SigW'(LampGreen);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [ChW-1:0]    ch_q, ch_d, ch_inc;
  logic              flash_on_q, flash_on_d;
  logic              to_ch0_q, to_ch0_d;
  logic [SigW-1:0]   sig_q, sig_d;
  logic [N_CH-1:0]   active_oh;
  logic              other_dem;
  logic [ChW-1:0]    sel_idx;
  logic              sel_valid;

  rr_next_sel #(
    .N_CH (N_CH)
  ) u_sel (
    .req_i   (t_i),
    .cur_i   (ch_q),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  assign active_oh = N_CH'(1) << ch_q;
  assign other_dem = |(t_i & ~active_oh);
  assign cnt_inc   = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
  assign ch_inc    = (ch_q == LastCh) ? '0 : ch_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StGreen;
      cnt_q      <= '0;
      ch_q       <= '0;
      flash_on_q <= 1'b0;
      to_ch0_q   <= 1'b0;
      sig_q      <= ResetSig;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      flash_on_q <= flash_on_d;
      to_ch0_q   <= to_ch0_d;
      sig_q      <= sig_d;
    end
  end

  // Flash request overrides every timer transition on the same edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc;
    ch_d       = ch_q;
    flash_on_d = flash_on_q;
    to_ch0_d   = to_ch0_q;
    if (flash_i) begin
      if (state_q != StFlash) begin
        state_d    = StFlash;
        cnt_d      = '0;
        flash_on_d = 1'b1;
      end else if (cnt_q == FlashLast) begin
        cnt_d      = '0;
        flash_on_d = ~flash_on_q;
      end
    end else begin
      unique case (state_q)
        StGreen: begin
          if (cnt_q >= MinLast && other_dem && (!t_i[ch_q] || cnt_q >= MaxLast)) begin
            state_d = StYellow;
            cnt_d   = '0;
          end
        end
        StYellow: begin
          if (cnt_q == YelLast) begin
            state_d = StAllRed;
            cnt_d   = '0;
          end
        end
        StAllRed: begin
          if (cnt_q == RedLast) begin
            state_d  = StGreen;
            cnt_d    = '0;
            to_ch0_d = 1'b0;
            if (to_ch0_q)       ch_d = '0;
            else if (sel_valid) ch_d = sel_idx;
            else                ch_d = ch_inc;
          end
        end
        StFlash: begin
          // Leaving maintenance always restarts from approach 0 after a full clearance.
          state_d    = StAllRed;
          cnt_d      = '0;
          flash_on_d = 1'b0;
          to_ch0_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Lamps are decoded from next-state so the registered outputs track the state exactly.
  always_comb begin
    sig_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      unique case (state_d)
        StGreen:  if (ch_d == ChW'(i)) sig_d[2*i +: 2] = LampGreen;
        StYellow: if (ch_d == ChW'(i)) sig_d[2*i +: 2] = LampYellow;
        StFlash:  sig_d[2*i +: 2] = flash_on_d ? LampYellow : LampRed;
        default:  sig_d[2*i +: 2] = LampRed;
      endcase
    end
  end

  assign sig_o       = sig_q;
  assign active_ch_o = ch_q;
  assign phase_o     = state_q;

endmodule
